// File: rtl/cola_pkg.sv
// Shared definitions for the cola vending machine: payout FSM state
// encodings, coin denominations and the default cola price. The
// coin-accepting FSM imports this package too.
package cola_pkg;

  // Payout FSM states. Encoded 1..6 so that an all-zero state register is
  // never a legal state.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd1,
    ST_COLA   = 4'd2,
    ST_GAP    = 4'd3,
    ST_COIN1  = 4'd4,
    ST_COIN05 = 4'd5,
    ST_DONE   = 4'd6
  } state_t;

  // Coin values in half-yuan units.
  localparam int COIN1_HALVES  = 2;
  localparam int COIN05_HALVES = 1;

  // Default cola price in half-yuan units (1.5 yuan).
  localparam int PRICE_HALVES_DEF = 3;

endpackage

// File: rtl/cola_pulse_timer.sv
// Loadable 32-bit down-counter used to time ejector pulses and the gaps
// between them. A load sets the count; the counter then steps down once per
// clock and parks at zero. expire is high while the count is zero, so a
// load value of N-1 gives an interval of N cycles.
module cola_pulse_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        expire
);

  logic [31:0] count;

  // Load takes priority; otherwise count down until zero and hold there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 32'd0) begin
      count <= count - 32'd1;
    end
  end

  assign expire = (count == 32'd0);

endmodule

// File: rtl/cola_change_out.sv
// Payout end of the cola vending machine. On an accepted vend request it
// pulses the cola ejector (if the credit covers the price), then pays the
// change greedily: all 1-yuan coins first, then at most one 0.5-yuan coin,
// with a quiet gap after every pulse. Credit below the price is refunded in
// full with no cola. All outputs are registered from the current state, so
// each ejector rises one cycle after its state is entered.
module cola_change_out
  import cola_pkg::*;
#(
  parameter int          PRICE_HALVES = PRICE_HALVES_DEF,
  parameter int          CREDIT_W     = 3,
  parameter logic [31:0] PULSE_CYC    = 32'd12_500_000,
  parameter logic [31:0] GAP_CYC      = 32'd12_500_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vend_req,
  input  logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                done,
  output logic                cola_out,
  output logic                coin1_out,
  output logic                coin05_out,
  output logic [7:0]          led
);

  // Constants sized to the credit width so the change arithmetic stays in
  // CREDIT_W bits.
  localparam logic [CREDIT_W-1:0] PRICE_W = CREDIT_W'(PRICE_HALVES);
  localparam logic [CREDIT_W-1:0] C1_W    = CREDIT_W'(COIN1_HALVES);
  localparam logic [CREDIT_W-1:0] C05_W   = CREDIT_W'(COIN05_HALVES);

  state_t              state;
  logic [CREDIT_W-1:0] chg;
  logic [3:0]          chg_led;
  logic                active;
  logic                credit_ok;
  logic                tmr_load;
  logic [31:0]         tmr_val;
  logic                tmr_expire;

  // Next payout step for a given amount still owed: biggest coin that fits,
  // or finish when nothing is owed.
  function automatic state_t coin_or_done(input logic [CREDIT_W-1:0] owed);
    if (owed >= C1_W) begin
      return ST_COIN1;
    end else if (owed >= C05_W) begin
      return ST_COIN05;
    end else begin
      return ST_DONE;
    end
  endfunction

  // Change shown on led[7:4]: zero-extended or truncated to four bits.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chg_led
      if (gi < CREDIT_W) begin : g_bit
        assign chg_led[gi] = chg[gi];
      end else begin : g_pad
        assign chg_led[gi] = 1'b0;
      end
    end
  endgenerate

  // Compared at 32 bits so a price larger than the credit range still works.
  assign credit_ok = (32'(credit) >= PRICE_HALVES);

  // Payout in progress: any state that drives or waits on an ejector.
  always_comb begin
    active = (state == ST_COLA) || (state == ST_GAP) ||
             (state == ST_COIN1) || (state == ST_COIN05);
  end

  // Timer reload on every state entry: pulse length when entering an
  // ejector state, gap length when entering GAP. A reload towards DONE is
  // harmless since DONE does not look at the timer.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = PULSE_CYC - 32'd1;
    case (state)
      ST_IDLE: begin
        if (vend_req) begin
          tmr_load = 1'b1;
        end
      end
      ST_COLA, ST_COIN1, ST_COIN05: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_CYC - 32'd1;
        end
      end
      ST_GAP: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
        end
      end
      default: begin
        tmr_load = 1'b0;
      end
    endcase
  end

  cola_pulse_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // Payout FSM with registered outputs derived from the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      chg        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cola_out   <= 1'b0;
      coin1_out  <= 1'b0;
      coin05_out <= 1'b0;
      led        <= 8'h00;
    end else begin
      busy       <= active;
      done       <= (state == ST_DONE);
      cola_out   <= (state == ST_COLA);
      coin1_out  <= (state == ST_COIN1);
      coin05_out <= (state == ST_COIN05);
      if (state == ST_IDLE) begin
        led <= 8'h00;
      end else begin
        led <= {chg_led, (state == ST_COIN05), (state == ST_COIN1),
                (state == ST_COLA), active};
      end

      case (state)
        ST_IDLE: begin
          // Credit is sampled only here; requests elsewhere are dropped.
          if (vend_req) begin
            if (credit_ok) begin
              chg   <= credit - PRICE_W;
              state <= ST_COLA;
            end else begin
              chg   <= credit;
              state <= coin_or_done(credit);
            end
          end
        end
        ST_COLA: begin
          if (tmr_expire) begin
            state <= ST_GAP;
          end
        end
        ST_COIN1: begin
          if (tmr_expire) begin
            chg   <= chg - C1_W;
            state <= ST_GAP;
          end
        end
        ST_COIN05: begin
          if (tmr_expire) begin
            chg   <= chg - C05_W;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr_expire) begin
            state <= coin_or_done(chg);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
